// File: rtl/uart_rx.sv
// uart_rx -- receive path of the picoRV memory-mapped UART.
//
// Samples the asynchronous rx pin, deserialises 8N1 frames (LSB first) and
// buffers the received bytes behind a valid/ready handshake toward the UART
// register block.
//
// Build option: define UART_RX_FIFO_EN to get a DEPTH-entry first-word
// fall-through FIFO. Without it, a single holding register is used and DEPTH
// is ignored.
//
// Handshake: a byte transfers on a rising clk edge where valid && ready.
// data_o is stable while valid is high and no transfer occurs. ready is
// ignored while valid is low.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   enable         receiver enable; low forces IDLE and drops a partial byte
//   baud_prescaler bit period in clk cycles (values below 4 act as 4)
//   rx             asynchronous serial input, idles high
//   data_o         byte at the head of the buffer
//   valid          data_o holds an unread byte
//   ready          consumer takes data_o this cycle
//   frame_err      one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: byte dropped because the buffer was full
//   busy           a frame is in progress
module uart_rx #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] baud_prescaler,
  input  logic        rx,
  output logic [7:0]  data_o,
  output logic        valid,
  input  logic        ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t      state;
  logic        rx_meta, rx_sync, rx_prev;
  logic        fall;
  logic [15:0] p_eff;
  logic [15:0] period;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        push_req;
  logic [7:0]  push_data;
  logic        pop;

  // rx_prev is the third flop; a fall is seen when it still holds 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall  = rx_prev & ~rx_sync;
  assign p_eff = (baud_prescaler < 16'd4) ? 16'd4 : baud_prescaler;
  assign busy  = (state != IDLE);
  assign pop   = valid & ready;

  // Receive FSM. The completed byte is handed to the buffer through a
  // registered push strobe, so the buffer updates one cycle after the stop
  // sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      period    <= 16'd4;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push_req  <= 1'b0;
      frame_err <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              period <= p_eff;
              cnt    <= {1'b0, p_eff[15:1]} - 16'd1;
              state  <= START;
            end
          end
          START: begin
            if (cnt == 16'd0) begin
              if (!rx_sync) begin
                cnt     <= period - 16'd1;
                bit_idx <= '0;
                state   <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          DATA: begin
            if (cnt == 16'd0) begin
              shift_reg[bit_idx] <= rx_sync;
              cnt                <= period - 16'd1;
              if (bit_idx == 3'd7) state <= STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          STOP: begin
            // Leaving at mid-stop-bit keeps the next start edge detectable.
            if (cnt == 16'd0) begin
              if (rx_sync) begin
                push_req  <= 1'b1;
                push_data <= shift_reg;
                state     <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BRK;
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          BRK: begin
            // A held-low line reports one error, then waits for idle.
            if (rx_sync) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]   count, count_next;
  logic          full, do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push_req & (~full | pop);
  assign rd_nxt  = rd_ptr + 1'b1;

  always_comb begin
    count_next = count;
    if (do_push && !pop) count_next = count + 1'b1;
    else if (pop && !do_push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // data_o is a registered copy of the head entry (first-word fall-through).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid   <= 1'b0;
      data_o  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_req & full & ~pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_nxt;
      count <= count_next;
      valid <= (count_next != '0);
      if (pop) begin
        if (count > (AW+1)'(1)) data_o <= mem[rd_nxt];
        else if (do_push) data_o <= push_data;
      end else if (count == '0 && do_push) begin
        data_o <= push_data;
      end
    end
  end
`else
  // Single holding register: a push is accepted when empty or when the
  // held byte is popped in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      data_o  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_req & valid & ~pop;
      if (push_req && (!valid || pop)) begin
        data_o <= push_data;
        valid  <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
    end
  end
`endif

endmodule
